// File: rtl/sockit_spi_arb.sv
// sockit_spi_arb: N-channel command arbiter with in-order write/read data routing by tag queues.
// Define SOCKIT_SPI_ARB_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sockit_spi_arb #(
    parameter int CN  = 2,
    parameter int CW  = 32,
    parameter int DW  = 32,
    parameter int WRB = 0,
    parameter int RDB = 1,
    parameter int TQD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CN-1:0]    si_vld,
    input  logic [CN-1:0]    si_lst,
    input  logic [CN*CW-1:0] si_dat,
    output logic [CN-1:0]    si_rdy,
    output logic             so_vld,
    output logic             so_lst,
    output logic [CW-1:0]    so_dat,
    input  logic             so_rdy,
    input  logic [CN-1:0]    wi_vld,
    input  logic [CN*DW-1:0] wi_dat,
    output logic [CN-1:0]    wi_rdy,
    output logic             wo_vld,
    output logic [DW-1:0]    wo_dat,
    input  logic             wo_rdy,
    input  logic             ri_vld,
    input  logic [DW-1:0]    ri_dat,
    output logic             ri_rdy,
    output logic [CN-1:0]    ro_vld,
    output logic [DW-1:0]    ro_dat,
    input  logic [CN-1:0]    ro_rdy,
    output logic [CN-1:0]    own
);
    localparam int IW = (CN > 1) ? $clog2(CN) : 1;
    localparam int PW = $clog2(TQD);
    localparam logic [PW:0] QD = (PW+1)'(TQD);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [IW-1:0] own_idx;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;

    logic [IW-1:0] wq_mem [TQD];
    logic [IW-1:0] rq_mem [TQD];
    logic [PW-1:0] wq_wp, wq_rp, rq_wp, rq_rp;
    logic [PW:0]   wq_cnt, rq_cnt;
    logic [IW-1:0] wq_h, rq_h;
    logic          wq_ne, rq_ne, wq_full, rq_full;
    logic          wq_push, wq_pop, rq_push, rq_pop;
    logic [CW-1:0] cmd;
    logic          cmd_ok, cmd_acc, cmd_end;

`ifdef SOCKIT_SPI_ARB_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = CN-1; k >= 0; k--) begin
            if (si_vld[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] rr_ptr;

    // Scan downwards so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        int c;
        c       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = CN-1; k >= 0; k--) begin
            c = (int'(rr_ptr) + k) % CN;
            if (si_vld[c]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            rr_ptr <= '0;
        else if (cmd_end)
            rr_ptr <= (own_idx == IW'(CN-1)) ? '0 : own_idx + 1'b1;
    end
`endif

    assign cmd     = si_dat[int'(own_idx)*CW +: CW];
    assign wq_ne   = (wq_cnt != '0);
    assign rq_ne   = (rq_cnt != '0);
    // A full queue still takes a push when its head leaves on the same edge.
    assign wq_full = (wq_cnt == QD) && !wq_pop;
    assign rq_full = (rq_cnt == QD) && !rq_pop;
    assign cmd_ok  = !(cmd[WRB] && wq_full) && !(cmd[RDB] && rq_full);
    assign so_vld  = (state == LOCK) && si_vld[own_idx] && cmd_ok;
    assign so_lst  = si_lst[own_idx];
    assign so_dat  = cmd;
    assign cmd_acc = so_vld && so_rdy;
    assign cmd_end = cmd_acc && si_lst[own_idx];
    assign wq_push = cmd_acc && cmd[WRB];
    assign rq_push = cmd_acc && cmd[RDB];

    assign wq_h   = wq_mem[wq_rp];
    assign wo_vld = wq_ne && wi_vld[wq_h];
    assign wo_dat = wi_dat[int'(wq_h)*DW +: DW];
    assign wq_pop = wo_vld && wo_rdy;

    assign rq_h   = rq_mem[rq_rp];
    assign ri_rdy = rq_ne && ro_rdy[rq_h];
    assign ro_dat = ri_dat;
    assign rq_pop = ri_vld && ri_rdy;

    always_comb begin
        si_rdy = '0;
        wi_rdy = '0;
        ro_vld = '0;
        for (int i = 0; i < CN; i++) begin
            si_rdy[i] = (state == LOCK) && (own_idx == IW'(i)) && so_rdy && cmd_ok;
            wi_rdy[i] = wq_ne && (wq_h == IW'(i)) && wo_rdy;
            ro_vld[i] = rq_ne && (rq_h == IW'(i)) && ri_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            own     <= '0;
            own_idx <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    state   <= LOCK;
                    own_idx <= gnt_idx;
                    own     <= CN'(1) << gnt_idx;
                end
                LOCK: if (cmd_end) begin
                    state <= IDLE;
                    own   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wq_push) wq_mem[wq_wp] <= own_idx;
        if (rq_push) rq_mem[rq_wp] <= own_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
            rq_wp  <= '0;
            rq_rp  <= '0;
            rq_cnt <= '0;
        end else begin
            if (wq_push) wq_wp <= wq_wp + 1'b1;
            if (wq_pop)  wq_rp <= wq_rp + 1'b1;
            if (rq_push) rq_wp <= rq_wp + 1'b1;
            if (rq_pop)  rq_rp <= rq_rp + 1'b1;
            case ({wq_push, wq_pop})
                2'b10:   wq_cnt <= wq_cnt + 1'b1;
                2'b01:   wq_cnt <= wq_cnt - 1'b1;
                default: wq_cnt <= wq_cnt;
            endcase
            case ({rq_push, rq_pop})
                2'b10:   rq_cnt <= rq_cnt + 1'b1;
                2'b01:   rq_cnt <= rq_cnt - 1'b1;
                default: rq_cnt <= rq_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Bench for sockit_spi_arb: random traffic against a queue-based reference model plus directed corner cases.
module tb_sockit_spi_arb;
    localparam int CN = 4, CW = 32, DW = 32, WRB = 0, RDB = 1, TQD = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic [CN-1:0] si_vld = '0, si_lst = '0, si_rdy;
    logic [CN*CW-1:0] si_dat = '0;
    logic so_vld, so_lst, so_rdy = 1'b0;
    logic [CW-1:0] so_dat;
    logic [CN-1:0] wi_vld = '0, wi_rdy;
    logic [CN*DW-1:0] wi_dat = '0;
    logic wo_vld, wo_rdy = 1'b0;
    logic [DW-1:0] wo_dat;
    logic ri_vld = 1'b0, ri_rdy;
    logic [DW-1:0] ri_dat = '0, ro_dat;
    logic [CN-1:0] ro_vld, ro_rdy = '0, own;

    sockit_spi_arb #(.CN(CN), .CW(CW), .DW(DW), .WRB(WRB), .RDB(RDB), .TQD(TQD)) dut (
        .clk(clk), .rst(rst),
        .si_vld(si_vld), .si_lst(si_lst), .si_dat(si_dat), .si_rdy(si_rdy),
        .so_vld(so_vld), .so_lst(so_lst), .so_dat(so_dat), .so_rdy(so_rdy),
        .wi_vld(wi_vld), .wi_dat(wi_dat), .wi_rdy(wi_rdy),
        .wo_vld(wo_vld), .wo_dat(wo_dat), .wo_rdy(wo_rdy),
        .ri_vld(ri_vld), .ri_dat(ri_dat), .ri_rdy(ri_rdy),
        .ro_vld(ro_vld), .ro_dat(ro_dat), .ro_rdy(ro_rdy),
        .own(own)
    );

    always #5 clk = ~clk;

    typedef logic [CW:0] cmd_q_t [$];
    typedef logic [DW-1:0] dat_q_t [$];

    cmd_q_t drv_cmd [CN];
    cmd_q_t exp_cmd [CN];
    dat_q_t drv_w [CN];
    dat_q_t exp_wch [CN];
    dat_q_t exp_w;
    dat_q_t exp_r;
    int rd_ch [$];
    int grant_log [$];
    int wq [$];
    int rq [$];

    bit m_lock = 0;
    int m_own = 0, m_rr = 0;
    int rd_acc_cnt = 0, acc_cnt = 0;
    bit chk_en = 0, dense = 0, ser_en = 0;
    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_none(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h while nothing was expected at %0t", name, act, $time);
    endtask

    task automatic add_cmd(input int ch, input logic lst, input logic [CW-1:0] d);
        logic [DW-1:0] w;
        drv_cmd[ch].push_back({lst, d});
        exp_cmd[ch].push_back({lst, d});
        if (d[WRB]) begin
            w = $urandom;
            drv_w[ch].push_back(w);
            exp_wch[ch].push_back(w);
        end
    endtask

    function automatic bit drained();
        bit ok;
        ok = !m_lock && wq.size() == 0 && rq.size() == 0 && exp_w.size() == 0
             && exp_r.size() == 0 && rd_ch.size() == 0 && si_vld == '0 && wi_vld == '0 && !ri_vld;
        for (int i = 0; i < CN; i++)
            ok = ok && drv_cmd[i].size() == 0 && exp_cmd[i].size() == 0 && drv_w[i].size() == 0;
        return ok;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            done = drained();
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    // Stimulus: upstream channels, write-data sources, serializer read beats and ready signals.
    initial begin : driver
        logic [CN-1:0] sf, wf;
        logic rf, rs;
        logic [CW:0] tc;
        int issued;
        issued = 0;
        forever begin
            @(negedge clk);
            sf = si_vld & si_rdy;
            wf = wi_vld & wi_rdy;
            rf = ri_vld & ri_rdy;
            rs = rst;
            @(posedge clk);
            #1;
            if (!rs) begin
                si_vld = '0;
                wi_vld = '0;
                ri_vld = 1'b0;
                issued = 0;
            end else begin
                for (int i = 0; i < CN; i++) begin
                    if (sf[i]) begin
                        void'(drv_cmd[i].pop_front());
                        si_vld[i] = 1'b0;
                    end
                    if (!si_vld[i] && drv_cmd[i].size() > 0 && (dense || $urandom_range(0, 3) != 0)) begin
                        tc = drv_cmd[i][0];
                        si_vld[i] = 1'b1;
                        si_lst[i] = tc[CW];
                        si_dat[i*CW +: CW] = tc[CW-1:0];
                    end
                    if (wf[i]) begin
                        void'(drv_w[i].pop_front());
                        wi_vld[i] = 1'b0;
                    end
                    if (!wi_vld[i] && drv_w[i].size() > 0 && (dense || $urandom_range(0, 2) != 0)) begin
                        wi_vld[i] = 1'b1;
                        wi_dat[i*DW +: DW] = drv_w[i][0];
                    end
                end
                if (rf) begin
                    ri_vld = 1'b0;
                    issued++;
                end
                if (!ri_vld && ser_en && issued < rd_acc_cnt && (dense || $urandom_range(0, 2) == 0)) begin
                    ri_vld = 1'b1;
                    ri_dat = $urandom;
                    exp_r.push_back(ri_dat);
                end
            end
            so_rdy = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
            wo_rdy = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
            ro_rdy = dense ? '1 : CN'($urandom);
        end
    end

    // Reference model: lock owner, rotation pointer and tag queues kept as plain queues.
    initial begin : monitor
        logic [CN-1:0] e_own, e_si_rdy, e_wi_rdy, e_ro_vld, prev_own;
        logic e_so_vld, e_wo_vld, e_ri_rdy, wpop, rpop, ok, acc;
        logic [CW-1:0] d;
        int wh, rh, c, gi;
        prev_own = '0;
        forever begin
            @(negedge clk);
            e_own = '0; e_si_rdy = '0; e_wi_rdy = '0; e_ro_vld = '0;
            e_so_vld = 0; e_wo_vld = 0; e_ri_rdy = 0; wpop = 0; rpop = 0; ok = 0; acc = 0; d = '0;
            if (wq.size() > 0) begin
                wh = wq[0];
                e_wo_vld = wi_vld[wh];
                e_wi_rdy[wh] = wo_rdy;
                wpop = e_wo_vld && wo_rdy;
            end
            if (rq.size() > 0) begin
                rh = rq[0];
                e_ro_vld[rh] = ri_vld;
                e_ri_rdy = ro_rdy[rh];
                rpop = ri_vld && e_ri_rdy;
            end
            if (m_lock) begin
                e_own[m_own] = 1'b1;
                d = si_dat[m_own*CW +: CW];
                ok = !(d[WRB] && wq.size() == TQD && !wpop) && !(d[RDB] && rq.size() == TQD && !rpop);
                e_so_vld = si_vld[m_own] && ok;
                e_si_rdy[m_own] = so_rdy && ok;
                acc = e_so_vld && so_rdy;
            end
            if (chk_en) begin
                check("ctrl", 64'({own, si_rdy, so_vld, wi_rdy, wo_vld, ri_rdy, ro_vld}),
                      64'({e_own, e_si_rdy, e_so_vld, e_wi_rdy, e_wo_vld, e_ri_rdy, e_ro_vld}));
                if (own != '0 && prev_own == '0) begin
                    gi = -1;
                    for (int i = 0; i < CN; i++) if (own[i]) gi = i;
                    grant_log.push_back(gi);
                end
                prev_own = own;
                if (so_vld && so_rdy) begin
                    acc_cnt++;
                    if (m_lock && exp_cmd[m_own].size() > 0)
                        check("so_cmd", 64'({so_lst, so_dat}), 64'(exp_cmd[m_own].pop_front()));
                    else
                        check_none("so_cmd", 64'({so_lst, so_dat}));
                end
                if (wo_vld && wo_rdy) begin
                    if (exp_w.size() > 0) check("wo_dat", 64'(wo_dat), 64'(exp_w.pop_front()));
                    else check_none("wo_dat", 64'(wo_dat));
                end
                for (int i = 0; i < CN; i++) begin
                    if (ro_vld[i] && ro_rdy[i]) begin
                        if (rd_ch.size() > 0 && exp_r.size() > 0) begin
                            check("ro_ch", 64'(i), 64'(rd_ch.pop_front()));
                            check("ro_dat", 64'(ro_dat), 64'(exp_r.pop_front()));
                        end else
                            check_none("ro_dat", 64'(ro_dat));
                    end
                end
            end
            if (!rst || !chk_en) begin
                m_lock = 0; m_own = 0; m_rr = 0;
                wq.delete(); rq.delete(); rd_ch.delete(); exp_w.delete(); exp_r.delete();
                rd_acc_cnt = 0;
            end else begin
                if (wpop) void'(wq.pop_front());
                if (rpop) void'(rq.pop_front());
                if (m_lock) begin
                    if (acc) begin
                        if (d[WRB]) begin
                            wq.push_back(m_own);
                            if (exp_wch[m_own].size() > 0) exp_w.push_back(exp_wch[m_own].pop_front());
                        end
                        if (d[RDB]) begin
                            rq.push_back(m_own);
                            rd_ch.push_back(m_own);
                            rd_acc_cnt++;
                        end
                        if (si_lst[m_own]) begin
                            m_lock = 0;
                            m_rr = (m_own + 1) % CN;
                        end
                    end
                end else if (si_vld != '0) begin
                    c = -1;
                    for (int k = CN-1; k >= 0; k--) begin
`ifdef SOCKIT_SPI_ARB_PRIO_EN
                        if (si_vld[k]) c = k;
`else
                        if (si_vld[(m_rr + k) % CN]) c = (m_rr + k) % CN;
`endif
                    end
                    m_own = c;
                    m_lock = 1;
                end
            end
        end
    end

    initial begin : main
        int rem [CN];
        int exp_g [$];
        int p, pick, acc0, n;
        logic [CW-1:0] d;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        check("rst_own", 64'(own), 64'd0);
        check("rst_si_rdy", 64'(si_rdy), 64'd0);
        check("rst_so_vld", 64'(so_vld), 64'd0);
        check("rst_wo_vld", 64'(wo_vld), 64'd0);
        check("rst_ri_rdy", 64'(ri_rdy), 64'd0);
        check("rst_ro_vld", 64'(ro_vld), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Random multi-command transactions on every channel
        ser_en = 1;
        for (int i = 0; i < CN; i++) begin
            for (int t = 0; t < 12; t++) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) add_cmd(i, k == n-1, $urandom);
            end
        end
        wait_drain("drain_random", 20000);

        // All channels request single-command transactions back to back
        dense = 1;
        grant_log.delete();
        p = m_rr;
        for (int i = 0; i < CN; i++) begin
            rem[i] = 2;
            for (int t = 0; t < 2; t++) begin
                d = $urandom;
                d[WRB] = 1'b0;
                d[RDB] = 1'b0;
                add_cmd(i, 1'b1, d);
            end
        end
        for (int k = 0; k < 2*CN; k++) begin
            pick = -1;
            for (int j = CN-1; j >= 0; j--) begin
`ifdef SOCKIT_SPI_ARB_PRIO_EN
                if (rem[j] > 0) pick = j;
`else
                if (rem[(p + j) % CN] > 0) pick = (p + j) % CN;
`endif
            end
            exp_g.push_back(pick);
            rem[pick]--;
            p = (pick + 1) % CN;
        end
        wait_drain("drain_grants", 2000);
        check("grant_count", 64'(grant_log.size()), 64'(2*CN));
        for (int k = 0; k < 2*CN && k < grant_log.size(); k++)
            check("grant_order", 64'(grant_log[k]), 64'(exp_g[k]));

        // Read-tag queue fills; the fifth read command stalls until a read beat drains a tag
        ser_en = 0;
        acc0 = acc_cnt;
        for (int k = 0; k < TQD + 1; k++) begin
            d = $urandom;
            d[WRB] = 1'b0;
            d[RDB] = 1'b1;
            add_cmd(0, k == TQD, d);
        end
        repeat (12) @(negedge clk);
        check("rq_full_acc", 64'(acc_cnt - acc0), 64'(TQD));
        check("rq_full_si_rdy0", 64'(si_rdy[0]), 64'd0);
        check("rq_full_so_vld", 64'(so_vld), 64'd0);
        check("rq_full_own", 64'(own), 64'b0001);
        ser_en = 1;
        wait_drain("drain_rq_full", 2000);
        check("rq_full_total", 64'(acc_cnt - acc0), 64'(TQD + 1));

        // Reset while channel 2 holds the lock with two read tags queued
        ser_en = 0;
        acc0 = acc_cnt;
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            d[WRB] = 1'b0;
            d[RDB] = 1'b1;
            add_cmd(2, 1'b0, d);
        end
        n = 0;
        while (acc_cnt - acc0 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("pre_rst_acc", 64'(acc_cnt - acc0), 64'd2);
        check("pre_rst_own", 64'(own), 64'b0100);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_own", 64'(own), 64'd0);
        check("mid_rst_si_rdy", 64'(si_rdy), 64'd0);
        check("mid_rst_so_vld", 64'(so_vld), 64'd0);
        check("mid_rst_wio", 64'({wi_rdy, wo_vld}), 64'd0);
        check("mid_rst_ri_rdy", 64'(ri_rdy), 64'd0);
        check("mid_rst_ro_vld", 64'(ro_vld), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Traffic after reset starts from empty queues
        dense = 0;
        ser_en = 1;
        for (int i = 0; i < CN; i++) begin
            for (int t = 0; t < 3; t++) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) add_cmd(i, k == n-1, $urandom);
            end
        end
        wait_drain("drain_post_rst", 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
